// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port.
// Load/store has priority, bounded by an anti-starvation counter for fetch.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [2:0]      ls_size,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic            ls_err,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            hlt,
  output logic            halted,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, IF_WAIT, LS_WAIT, RESP, HALTED} state_e;

  localparam int SW = $clog2(STARVE_MAX + 1);

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] size, input logic [XLEN-1:0] wd);
    case (size[1:0])
      2'b00:   return XLEN'({4{wd[7:0]}});
      2'b01:   return XLEN'({2{wd[15:0]}});
      default: return wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                               input logic [XLEN-1:0] word);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            is_ls_q, is_ls_d;
  logic            err_q, err_d;
  logic            hlt_seen_q, hlt_seen_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [2:0]      size_q, size_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            if_gnt_c, ls_gnt_c, if_rv_c, ls_rv_c, ls_err_c;
  logic            fetch_wins, in_wait;

  assign fetch_wins = if_req && (!ls_req || starve_q == SW'(STARVE_MAX));
  assign in_wait    = (state_q == IF_WAIT) || (state_q == LS_WAIT);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    is_ls_d    = is_ls_q;
    err_d      = err_q;
    hlt_seen_d = hlt_seen_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    if_gnt_c   = 1'b0;
    ls_gnt_c   = 1'b0;
    if_rv_c    = 1'b0;
    ls_rv_c    = 1'b0;
    ls_err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hlt) begin
          state_d = HALTED;
        end else if (fetch_wins) begin
          if_gnt_c = 1'b1;
          starve_d = '0;
          tmo_d    = '0;
          is_ls_d  = 1'b0;
          err_d    = 1'b0;
          addr_d   = if_addr;
          we_d     = 1'b0;
          size_d   = 3'b010;
          wstrb_d  = 4'b0000;
          state_d  = IF_WAIT;
        end else if (ls_req) begin
          ls_gnt_c = 1'b1;
          if (if_req && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
          tmo_d    = '0;
          is_ls_d  = 1'b1;
          addr_d   = ls_addr;
          we_d     = ls_we;
          size_d   = ls_size;
          wstrb_d  = ls_we ? lane_strb(ls_size, ls_addr[1:0]) : 4'b0000;
          wdata_d  = lane_wdata(ls_size, ls_wdata);
          rdata_d  = '0;
          // Misaligned accesses never reach memory; they answer with an error next cycle.
          if (misaligned(ls_size, ls_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = LS_WAIT;
          end
        end
      end
      IF_WAIT, LS_WAIT: begin
        if (hlt) hlt_seen_d = 1'b1;
        if (mem_ready) begin
          rdata_d = !is_ls_q ? mem_rdata :
                    (we_q ? '0 : load_ext(size_q, addr_q[1:0], mem_rdata));
          state_d = RESP;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = is_ls_q;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP: begin
        if_rv_c    = !is_ls_q;
        ls_rv_c    = is_ls_q;
        ls_err_c   = is_ls_q && err_q;
        state_d    = (hlt_seen_q || hlt) ? HALTED : IDLE;
        hlt_seen_d = 1'b0;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      tmo_q      <= '0;
      is_ls_q    <= 1'b0;
      err_q      <= 1'b0;
      hlt_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      is_ls_q    <= is_ls_d;
      err_q      <= err_d;
      hlt_seen_q <= hlt_seen_d;
    end
  end

  // Datapath registers are qualified by state at the outputs, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    size_q  <= size_d;
    wstrb_q <= wstrb_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign if_gnt    = if_gnt_c && rst_n;
  assign ls_gnt    = ls_gnt_c && rst_n;
  assign if_rvalid = if_rv_c;
  assign ls_rvalid = ls_rv_c;
  assign ls_err    = ls_err_c;
  assign if_rdata  = if_rv_c ? rdata_q : '0;
  assign ls_rdata  = ls_rv_c ? rdata_q : '0;
  assign mem_req   = in_wait;
  assign mem_we    = in_wait && we_q;
  assign mem_addr  = in_wait ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wstrb = in_wait ? wstrb_q : 4'b0000;
  assign mem_wdata = in_wait ? wdata_q : '0;
  assign halted    = (state_q == HALTED);
  assign busy      = in_wait || (state_q == RESP);

endmodule
